// File: rtl/block_dispatcher_pkg.sv
// Shared types for the thread-block dispatcher: top FSM and per-core slot states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } dispatch_state_t;

  typedef enum logic [1:0] {
    FREE,
    LOADING,
    RUNNING
  } core_slot_t;

endpackage

// File: rtl/block_dispatcher_if.sv
// Dispatcher-to-core bus: per-core reset/start pulses, block id/size, and completion.
// Latency: n/a (wiring only).
// Backpressure: a core holds core_done until its core_start drops; no other flow control.
// Modports: master = dispatcher (drives core_reset/core_start/core_block_id/core_thread_count),
//           slave  = cores (drive core_done). Id/count are flattened, core k at [k*TC_BITS +: TC_BITS].
interface block_dispatcher_if #(
  parameter int NUM_CORES = 2,
  parameter int TC_BITS   = 8
);
  logic [NUM_CORES-1:0]         core_reset;
  logic [NUM_CORES-1:0]         core_start;
  logic [NUM_CORES*TC_BITS-1:0] core_block_id;
  logic [NUM_CORES*TC_BITS-1:0] core_thread_count;
  logic [NUM_CORES-1:0]         core_done;

  modport master (
    output core_reset,
    output core_start,
    output core_block_id,
    output core_thread_count,
    input  core_done
  );

  modport slave (
    input  core_reset,
    input  core_start,
    input  core_block_id,
    input  core_thread_count,
    output core_done
  );
endinterface

// File: rtl/block_dispatcher_core_slot.sv
// One core's slot: FREE -> LOADING (core_reset pulse) -> RUNNING (core_start high) -> FREE.
// Latency: core_reset the cycle after select, core_start the cycle after that.
// Backpressure: not free while LOADING/RUNNING; core_done is ignored outside RUNNING.
// Ports: clk, reset, select, load_id, load_count, core_done in;
//        core_reset, core_start, block_id, thread_count, is_free, retire out.
import gpu_pkg::*;

module core_slot #(
  parameter int TC_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               select,
  input  logic [TC_BITS-1:0] load_id,
  input  logic [TC_BITS-1:0] load_count,
  input  logic               core_done,
  output logic               core_reset,
  output logic               core_start,
  output logic [TC_BITS-1:0] block_id,
  output logic [TC_BITS-1:0] thread_count,
  output logic               is_free,
  output logic               retire
);

  core_slot_t slot_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q       <= FREE;
      core_reset   <= 1'b0;
      core_start   <= 1'b0;
      block_id     <= '0;
      thread_count <= '0;
    end else begin
      core_reset <= 1'b0;
      case (slot_q)
        FREE: begin
          if (select) begin
            slot_q       <= LOADING;
            core_reset   <= 1'b1;
            block_id     <= load_id;
            thread_count <= load_count;
          end
        end
        LOADING: begin
          slot_q     <= RUNNING;
          core_start <= 1'b1;
        end
        RUNNING: begin
          if (core_done) begin
            slot_q     <= FREE;
            core_start <= 1'b0;
          end
        end
        default: slot_q <= FREE;
      endcase
    end
  end

  // A slot retiring this cycle is still RUNNING, so it only becomes eligible next cycle.
  assign is_free = (slot_q == FREE);
  assign retire  = (slot_q == RUNNING) && core_done;

endmodule

// File: rtl/block_dispatcher.sv
// Dynamic block scheduler: splits thread_count into THREADS_PER_BLOCK blocks, hands each to the next free core.
// Latency: start -> first core_reset 2 cycles, first core_start 3 cycles; done 1 cycle after retired reaches total.
// Backpressure: at most one dispatch per cycle, only to a FREE slot; stalls while all cores are busy.
// Ports: clk, reset, start, thread_count in; cores (block_dispatcher_if.master) bus; done out.
// Optional: DISPATCH_STATS_EN adds busy_cycles[15:0], saturating DISPATCH+DRAIN cycle count.
import gpu_pkg::*;

module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_BITS           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TC_BITS-1:0] thread_count,
  block_dispatcher_if.master cores,
  output logic               done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]        busy_cycles
`endif
);

  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int CW       = TC_BITS + 1;
  localparam int WW       = CW + LOG2_TPB;

  dispatch_state_t state;
  logic [TC_BITS-1:0] tc_q;
  logic [CW-1:0]      total_blocks;
  logic [CW-1:0]      dispatched;
  logic [CW-1:0]      retired;

  logic [NUM_CORES-1:0]         slot_free;
  logic [NUM_CORES-1:0]         slot_retire;
  logic [NUM_CORES-1:0]         slot_sel;
  logic [NUM_CORES-1:0]         reset_vec;
  logic [NUM_CORES-1:0]         start_vec;
  logic [NUM_CORES*TC_BITS-1:0] id_flat;
  logic [NUM_CORES*TC_BITS-1:0] cnt_flat;

  logic               can_dispatch;
  logic               dispatch_fire;
  logic [CW-1:0]      retire_cnt;
  logic [CW-1:0]      launch_blocks;
  logic [WW-1:0]      remaining;
  logic [TC_BITS-1:0] next_count;

  // ceil(tc / TPB), done in TC_BITS+1 bits so tc near full scale cannot wrap.
  assign launch_blocks = (CW'(thread_count) + CW'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;

  // Threads left for the block about to go out; the last block takes the remainder.
  assign remaining  = WW'(tc_q) - (WW'(dispatched) << LOG2_TPB);
  assign next_count = (remaining >= WW'(THREADS_PER_BLOCK)) ? TC_BITS'(THREADS_PER_BLOCK)
                                                            : remaining[TC_BITS-1:0];

  assign can_dispatch = (state == DISPATCH) && (dispatched != total_blocks);

  // Lowest-index free slot wins.
  always_comb begin
    logic found;
    slot_sel = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (can_dispatch && slot_free[k] && !found) begin
        slot_sel[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign dispatch_fire = |slot_sel;

  // Several cores may retire in the same cycle.
  always_comb begin
    retire_cnt = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      retire_cnt = retire_cnt + CW'(slot_retire[k]);
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
    core_slot #(
      .TC_BITS(TC_BITS)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .select       (slot_sel[k]),
      .load_id      (dispatched[TC_BITS-1:0]),
      .load_count   (next_count),
      .core_done    (cores.core_done[k]),
      .core_reset   (reset_vec[k]),
      .core_start   (start_vec[k]),
      .block_id     (id_flat[k*TC_BITS +: TC_BITS]),
      .thread_count (cnt_flat[k*TC_BITS +: TC_BITS]),
      .is_free      (slot_free[k]),
      .retire       (slot_retire[k])
    );
  end

  assign cores.core_reset        = reset_vec;
  assign cores.core_start        = start_vec;
  assign cores.core_block_id     = id_flat;
  assign cores.core_thread_count = cnt_flat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tc_q         <= '0;
      total_blocks <= '0;
      dispatched   <= '0;
      retired      <= '0;
      done         <= 1'b0;
    end else begin
      dispatched <= dispatched + CW'(dispatch_fire);
      retired    <= retired + retire_cnt;
      case (state)
        IDLE: begin
          if (start) begin
            tc_q         <= thread_count;
            total_blocks <= launch_blocks;
            state        <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (dispatched == total_blocks) state <= DRAIN;
        end
        DRAIN: begin
          if (retired == total_blocks) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cycles <= '0;
    end else if (((state == DISPATCH) || (state == DRAIN)) && (busy_cycles != 16'hFFFF)) begin
      busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (2 cores, 4 threads/block); cores finish ~5 cycles after core_start.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_block_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] thread_count;
  logic       done;
`ifdef DISPATCH_STATS_EN
  logic [15:0] busy_cycles;
`endif

  block_dispatcher_if #(.NUM_CORES(2), .TC_BITS(8)) cif ();

  block_dispatcher #(
    .NUM_CORES(2),
    .THREADS_PER_BLOCK(4),
    .TC_BITS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_count (thread_count),
    .cores        (cif),
    .done         (done)
`ifdef DISPATCH_STATS_EN
    ,
    .busy_cycles  (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Core model and pulse monitor, both on the falling edge.
  logic       manual = 1'b0;
  logic [1:0] man_done = 2'b00;
  int         run_cnt [2] = '{0, 0};
  logic [1:0] model_done;
  int         rst_pulses = 0;
  int         start_cycles = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cif.core_start[k] !== 1'b1) run_cnt[k] = 0;
      else if (run_cnt[k] < 7) run_cnt[k] = run_cnt[k] + 1;
      model_done[k] = (run_cnt[k] >= 6);
    end
    cif.core_done = manual ? man_done : model_done;
    rst_pulses    = rst_pulses + $countones(cif.core_reset);
    start_cycles  = start_cycles + $countones(cif.core_start);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic launch(input logic [7:0] tc);
    thread_count = tc;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  int p0;
  int s0;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    thread_count = 8'd0;
    tick();
    chk("rst_core_reset", cif.core_reset, 2'b00);
    chk("rst_core_start", cif.core_start, 2'b00);
    chk("rst_block_id", cif.core_block_id, 16'h0000);
    chk("rst_thread_cnt", cif.core_thread_count, 16'h0000);
    chk("rst_done", done, 1'b0);
`ifdef DISPATCH_STATS_EN
    chk("rst_busy", busy_cycles, 16'd0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_done", done, 1'b0);

    // 1: tc=8 -> two full blocks, one per core.
    p0 = rst_pulses;
    launch(8'd8);
    chk("t1_e0_reset", cif.core_reset, 2'b00);
    tick();
    chk("t1_e1_reset", cif.core_reset, 2'b01);
    chk("t1_e1_start", cif.core_start, 2'b00);
    chk("t1_id0", cif.core_block_id[7:0], 8'd0);
    chk("t1_cnt0", cif.core_thread_count[7:0], 8'd4);
    tick();
    chk("t1_e2_reset", cif.core_reset, 2'b10);
    chk("t1_e2_start", cif.core_start, 2'b01);
    chk("t1_id1", cif.core_block_id[15:8], 8'd1);
    chk("t1_cnt1", cif.core_thread_count[15:8], 8'd4);
    tick();
    chk("t1_e3_start", cif.core_start, 2'b11);
    chk("t1_e3_reset", cif.core_reset, 2'b00);
    ticks(5);
    chk("t1_e8_start", cif.core_start, 2'b10);
    tick();
    chk("t1_e9_start", cif.core_start, 2'b00);
    chk("t1_e9_done", done, 1'b0);
    tick();
    chk("t1_e10_done", done, 1'b1);
`ifdef DISPATCH_STATS_EN
    chk("t1_busy", busy_cycles, 16'd10);
    ticks(3);
    chk("t1_busy_frozen", busy_cycles, 16'd10);
`endif
    chk("t1_pulses", rst_pulses - p0, 2);

    // 2: tc=10 -> 3 blocks; partial block goes to core0, freed first.
    do_reset();
    p0 = rst_pulses;
    launch(8'd10);
    ticks(8);
    chk("t2_e8_start", cif.core_start, 2'b10);
    tick();
    chk("t2_e9_reset", cif.core_reset, 2'b01);
    chk("t2_e9_start", cif.core_start, 2'b00);
    chk("t2_id0", cif.core_block_id[7:0], 8'd2);
    chk("t2_cnt0", cif.core_thread_count[7:0], 8'd2);
    tick();
    chk("t2_e10_start", cif.core_start, 2'b01);
    ticks(6);
    chk("t2_retired", dut.retired, 9'd3);
    chk("t2_e16_done", done, 1'b0);
    tick();
    chk("t2_e17_done", done, 1'b1);
    chk("t2_pulses", rst_pulses - p0, 3);

    // 3: tc=0 -> no blocks, done after DISPATCH and DRAIN pass; start then ignored.
    do_reset();
    p0 = rst_pulses;
    s0 = start_cycles;
    launch(8'd0);
    tick();
    chk("t3_e1_done", done, 1'b0);
    tick();
    chk("t3_e2_done", done, 1'b1);
    start = 1'b1;
    thread_count = 8'd8;
    ticks(4);
    start = 1'b0;
    chk("t3_done_held", done, 1'b1);
    chk("t3_pulses", rst_pulses - p0, 0);
    chk("t3_starts", start_cycles - s0, 0);

    // 4: core_done ignored while FREE/LOADING, then both cores retire together.
    do_reset();
    manual   = 1'b1;
    man_done = 2'b11;
    launch(8'd8);
    ticks(2);
    man_done = 2'b00;
    tick();
    chk("t4_e3_start", cif.core_start, 2'b11);
    chk("t4_e3_retired", dut.retired, 9'd0);
    tick();
    man_done = 2'b11;
    tick();
    chk("t4_e5_retired", dut.retired, 9'd2);
    chk("t4_e5_start", cif.core_start, 2'b00);
    chk("t4_e5_done", done, 1'b0);
    man_done = 2'b00;
    tick();
    chk("t4_e6_done", done, 1'b1);
    manual = 1'b0;

    // 5: reset while both cores run, then relaunch.
    do_reset();
    launch(8'd16);
    ticks(4);
    chk("t5_running", cif.core_start, 2'b11);
    do_reset();
    chk("t5_rst_reset", cif.core_reset, 2'b00);
    chk("t5_rst_start", cif.core_start, 2'b00);
    chk("t5_rst_id", cif.core_block_id, 16'h0000);
    chk("t5_rst_cnt", cif.core_thread_count, 16'h0000);
    chk("t5_rst_done", done, 1'b0);
    launch(8'd4);
    tick();
    chk("t5_e1_reset", cif.core_reset, 2'b01);
    chk("t5_e1_id0", cif.core_block_id[7:0], 8'd0);
    chk("t5_e1_cnt0", cif.core_thread_count[7:0], 8'd4);
    ticks(7);
    chk("t5_e8_start", cif.core_start, 2'b00);
    chk("t5_e8_done", done, 1'b0);
    tick();
    chk("t5_e9_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
